// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch and branch unit for the 8-bit processor. On a one-cycle
// ir_load request from the control unit it reads the opcode byte at pc into
// ir and advances pc. Flow-control opcodes also fetch a target byte and are
// resolved here, with a small hardware return stack serving CALL/RET. The
// control unit decodes only after ir_valid.
//
// Parameters
//   ADDR_W       program address width; pc wraps modulo 2^ADDR_W
//   STACK_DEPTH  number of return-stack entries
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high
//   ir_load      in   fetch request, honoured only while idle
//   zero_flag    in   ALU zero flag, used to resolve JZ/JNZ
//   mem_rdata    in   program memory read data, valid with mem_ack
//   mem_ack      in   memory read complete, ignored while mem_req is low
//   mem_req      out  memory read request
//   mem_addr     out  read address (direct copy of pc)
//   ir           out  instruction register
//   ir_valid     out  one-cycle pulse: ir holds a completed instruction
//   pc           out  program counter
//   busy         out  high whenever a fetch is in progress
//   sp           out  number of occupied return-stack entries
//   stack_fault  out  one-cycle pulse: CALL on a full stack / RET on empty
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             ir_load,
  input  logic                             zero_flag,
  input  logic [7:0]                       mem_rdata,
  input  logic                             mem_ack,
  output logic                             mem_req,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [7:0]                       ir,
  output logic                             ir_valid,
  output logic [ADDR_W-1:0]                pc,
  output logic                             busy,
  output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
  output logic                             stack_fault
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  // FSM encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_OP_REQ   = 3'd1;
  localparam logic [2:0] ST_TGT_REQ  = 3'd2;
  localparam logic [2:0] ST_BR_EXEC  = 3'd3;
  localparam logic [2:0] ST_RET_EXEC = 3'd4;

  // Flow-control opcodes; every other byte is a plain opcode
  localparam logic [7:0] OP_JMP  = 8'h81;
  localparam logic [7:0] OP_CALL = 8'h82;
  localparam logic [7:0] OP_RET  = 8'h83;
  localparam logic [7:0] OP_GOTO = 8'h84;
  localparam logic [7:0] OP_JZ   = 8'h85;
  localparam logic [7:0] OP_JNZ  = 8'h87;

  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
  localparam logic [SP_W-1:0]   SP_ONE  = SP_W'(1);
  localparam logic [SP_W-1:0]   SP_ZERO = '0;
  localparam logic [SP_W-1:0]   SP_FULL = SP_W'(STACK_DEPTH);

  // Control state (asynchronously reset)
  logic [2:0]        state_q,       state_d;
  logic [ADDR_W-1:0] pc_q,          pc_d;
  logic [7:0]        ir_q,          ir_d;
  logic [SP_W-1:0]   sp_q,          sp_d;
  logic              mem_req_q,     mem_req_d;
  logic              ir_valid_q,    ir_valid_d;
  logic              busy_q,        busy_d;
  logic              stack_fault_q, stack_fault_d;

  // Datapath state (no reset: always written before it is read)
  logic [ADDR_W-1:0] tgt_q,   tgt_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_inc;

  // Opcodes that carry a second (target) byte
  function automatic logic has_target(input logic [7:0] op);
    return (op == OP_JMP) || (op == OP_CALL) || (op == OP_GOTO) ||
           (op == OP_JZ)  || (op == OP_JNZ);
  endfunction

  // Map a memory byte onto an address: low ADDR_W bits, zero-extended when
  // the address is wider than a byte.
  function automatic logic [ADDR_W-1:0] byte_to_addr(input logic [7:0] b);
    logic [ADDR_W-1:0] a;
    a = '0;
    for (int i = 0; i < ADDR_W && i < 8; i++) begin
      a[i] = b[i];
    end
    return a;
  endfunction

  // Natural-width add gives the required modulo 2^ADDR_W wrap
  assign pc_inc = pc_q + PC_ONE;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    sp_d          = sp_q;
    tgt_d         = tgt_q;
    ir_valid_d    = 1'b0;
    stack_fault_d = 1'b0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      stack_d[i] = stack_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (ir_load) begin
          state_d = ST_OP_REQ;
        end
      end

      ST_OP_REQ: begin
        if (mem_ack) begin
          ir_d = mem_rdata;
          pc_d = pc_inc;
          if (has_target(mem_rdata)) begin
            state_d = ST_TGT_REQ;
          end else if (mem_rdata == OP_RET) begin
            state_d = ST_RET_EXEC;
          end else begin
            state_d    = ST_IDLE;
            ir_valid_d = 1'b1;
          end
        end
      end

      ST_TGT_REQ: begin
        if (mem_ack) begin
          tgt_d   = byte_to_addr(mem_rdata);
          pc_d    = pc_inc;
          state_d = ST_BR_EXEC;
        end
      end

      ST_BR_EXEC: begin
        state_d    = ST_IDLE;
        ir_valid_d = 1'b1;
        case (ir_q)
          OP_JMP, OP_GOTO: pc_d = tgt_q;
          OP_JZ:           if (zero_flag)  pc_d = tgt_q;
          OP_JNZ:          if (!zero_flag) pc_d = tgt_q;
          OP_CALL: begin
            if (sp_q == SP_FULL) begin
              // Full stack: the call is dropped and execution falls through
              stack_fault_d = 1'b1;
            end else begin
              // Stack is a shift register with the top of stack in entry 0,
              // so pushes and pops never need a variable index.
              for (int i = STACK_DEPTH - 1; i > 0; i--) begin
                stack_d[i] = stack_q[i-1];
              end
              stack_d[0] = pc_q;
              sp_d       = sp_q + SP_ONE;
              pc_d       = tgt_q;
            end
          end
          default: ;
        endcase
      end

      ST_RET_EXEC: begin
        state_d    = ST_IDLE;
        ir_valid_d = 1'b1;
        if (sp_q == SP_ZERO) begin
          stack_fault_d = 1'b1;
        end else begin
          pc_d = stack_q[0];
          for (int i = 0; i < STACK_DEPTH - 1; i++) begin
            stack_d[i] = stack_q[i+1];
          end
          sp_d = sp_q - SP_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered outputs derived from the state being entered, so they line
    // up with the state itself rather than lagging it by a cycle.
    mem_req_d = (state_d == ST_OP_REQ) || (state_d == ST_TGT_REQ);
    busy_d    = (state_d != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      ir_q          <= '0;
      sp_q          <= '0;
      mem_req_q     <= 1'b0;
      ir_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      stack_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      sp_q          <= sp_d;
      mem_req_q     <= mem_req_d;
      ir_valid_q    <= ir_valid_d;
      busy_q        <= busy_d;
      stack_fault_q <= stack_fault_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    tgt_q <= tgt_d;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      stack_q[i] <= stack_d[i];
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign ir          = ir_q;
  assign ir_valid    = ir_valid_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign sp          = sp_q;
  assign stack_fault = stack_fault_q;

endmodule
